// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- integer ALU for the Execute stage of the RV32-style core.
//
// Computes arithmetic, logic, shift, compare and multiply results and
// evaluates branch conditions. Both outputs are registered, so a result
// appears one clock after its operands and op are sampled. There is no
// handshake: the ALU accepts one op per cycle.
//
// Ports:
//   clk     in   1      core clock, rising-edge
//   rst_n   in   1      asynchronous active-low reset (clears result/branch)
//   a       in   WIDTH  operand A, signed two's complement
//   b       in   WIDTH  operand B, signed two's complement (reg or immediate)
//   alu_op  in   4      operation select
//   result  out  WIDTH  registered operation result
//   branch  out  1      registered branch-taken flag
//
// Configuration macro: ALU_MUL_EN
//   defined   -> MUL/MULH use a single-cycle signed 32x32->64 multiplier
//   undefined -> no multiplier; MUL/MULH return 0 with branch=0
// ---------------------------------------------------------------------------
module alu #(
  parameter int WIDTH     = 32,
  parameter int LUI_SHAMT = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] result,
  output logic             branch
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_LUI  = 4'b1010;
  localparam logic [3:0] OP_MULH = 4'b1011;
  localparam logic [3:0] OP_BEQ  = 4'b1100;
  localparam logic [3:0] OP_BNE  = 4'b1101;
  localparam logic [3:0] OP_BGT  = 4'b1110;
  localparam logic [3:0] OP_BLT  = 4'b1111;

  logic [4:0]       shamt;
  logic             eq;
  logic             lt_s;
  logic             gt_s;
  logic [WIDTH-1:0] result_d;
  logic             branch_d;

  // Only the low five bits of b select the shift distance.
  assign shamt = b[4:0];
  assign eq    = (a == b);
  assign lt_s  = ($signed(a) < $signed(b));
  assign gt_s  = ($signed(a) > $signed(b));

`ifdef ALU_MUL_EN
  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] b_ext;
  logic signed [2*WIDTH-1:0] prod;

  // Explicit sign extension keeps the product a true signed 64-bit value.
  assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod  = a_ext * b_ext;
`endif

  always_comb begin
    result_d = '0;
    branch_d = 1'b0;
    case (alu_op)
      OP_ADD:  result_d = a + b;
      OP_SUB:  result_d = a - b;
      OP_XOR:  result_d = a ^ b;
      OP_OR:   result_d = a | b;
      OP_AND:  result_d = a & b;
      OP_SLL:  result_d = a << shamt;
      OP_SRL:  result_d = a >> shamt;
      OP_SRA:  result_d = $signed(a) >>> shamt;
      OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, lt_s};
      OP_LUI:  result_d = b << LUI_SHAMT;
`ifdef ALU_MUL_EN
      OP_MUL:  result_d = prod[WIDTH-1:0];
      OP_MULH: result_d = prod[2*WIDTH-1:WIDTH];
`else
      OP_MUL:  result_d = '0;
      OP_MULH: result_d = '0;
`endif
      // Branch ops drive an all-ones result so a stray writeback is obvious.
      OP_BEQ: begin
        result_d = '1;
        branch_d = eq;
      end
      OP_BNE: begin
        result_d = '1;
        branch_d = ~eq;
      end
      OP_BGT: begin
        result_d = '1;
        branch_d = gt_s;
      end
      OP_BLT: begin
        result_d = '1;
        branch_d = lt_s;
      end
      default: begin
        result_d = '0;
        branch_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      branch <= 1'b0;
    end else begin
      result <= result_d;
      branch <= branch_d;
    end
  end

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu.
//
// A behavioural model computes the expected registered outputs from the op
// table using plain 64-bit arithmetic; a compare process checks the DUT
// against it on every falling edge once reset has been released. Directed
// vectors with hand-computed literals pin the model, then random operands
// per op and a back-to-back random-op burst exercise the datapath.
// ---------------------------------------------------------------------------
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_op;
  logic [31:0] result;
  logic        branch;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic mul_on;

  logic [31:0] exp_result;
  logic        exp_branch;

  alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .alu_op (alu_op),
    .result (result),
    .branch (branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [3:0] op, input logic [31:0] va,
                                input logic [31:0] vb, output logic [31:0] r,
                                output logic br);
    longint sa, sb, p;
    int     ia, ib;
    int     sh;
    ia = va;
    ib = vb;
    sa = ia;
    sb = ib;
    p  = sa * sb;
    sh = vb % 32;
    br = 1'b0;
    r  = 32'h0;
    case (op)
      4'd0:  r = va + vb;
      4'd1:  r = va - vb;
      4'd2:  r = va ^ vb;
      4'd3:  r = va | vb;
      4'd4:  r = va & vb;
      4'd5:  r = va << sh;
      4'd6:  r = va >> sh;
      4'd7:  r = ia >>> sh;
      4'd8:  r = (ia < ib) ? 32'd1 : 32'd0;
      4'd9:  r = mul_on ? p[31:0] : 32'h0;
      4'd10: r = vb * 32'd4096;
      4'd11: r = mul_on ? p[63:32] : 32'h0;
      4'd12: begin r = 32'hFFFF_FFFF; br = (ia == ib); end
      4'd13: begin r = 32'hFFFF_FFFF; br = (ia != ib); end
      4'd14: begin r = 32'hFFFF_FFFF; br = (ia > ib);  end
      default: begin r = 32'hFFFF_FFFF; br = (ia < ib); end
    endcase
  endfunction

  // Model of the registered outputs: same sampling instant as the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_result = 32'h0;
      exp_branch = 1'b0;
    end else begin
      model(alu_op, a, b, exp_result, exp_branch);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_result", result, exp_result);
      chk("model_branch", {31'b0, branch}, {31'b0, exp_branch});
    end
  end

  task automatic vec(input string name, input logic [3:0] op,
                     input logic [31:0] va, input logic [31:0] vb,
                     input logic [31:0] er, input logic eb);
    @(posedge clk);
    #1;
    a = va;
    b = vb;
    alu_op = op;
    @(posedge clk);
    @(negedge clk);
    chk(name, result, er);
    chk({name, "_br"}, {31'b0, branch}, {31'b0, eb});
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 9))
      0: v = 32'h0000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'h7FFF_FFFF;
      4: v = 32'h0000_0001;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
`ifdef ALU_MUL_EN
    mul_on = 1'b1;
`else
    mul_on = 1'b0;
`endif
    rst_n  = 1'b1;
    a      = 32'd5;
    b      = 32'd7;
    alu_op = 4'b0000;

    // Reset asserted between clock edges must clear outputs at once.
    #1 rst_n = 1'b0;
    #1;
    chk("reset_result", result, 32'h0);
    chk("reset_branch", {31'b0, branch}, 32'h0);

    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("first_add", result, 32'd12);
    chk("first_add_br", {31'b0, branch}, 32'h0);
    chk_en = 1'b1;

    vec("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0);
    vec("sub_wrap", 4'b0001, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0);
    vec("xor", 4'b0010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0);
    vec("or",  4'b0011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0);
    vec("and", 4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0);
    vec("sll", 4'b0101, 32'h8000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0);
    vec("srl", 4'b0110, 32'h8000_0001, 32'h0000_0021, 32'h4000_0000, 1'b0);
    vec("sra", 4'b0111, 32'h8000_0001, 32'h0000_0021, 32'hC000_0000, 1'b0);
    vec("sll_zero", 4'b0101, 32'h8765_4321, 32'hFFFF_FFE0, 32'h8765_4321, 1'b0);
    vec("sra_31", 4'b0111, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0);
    vec("lui", 4'b1010, 32'hDEAD_BEEF, 32'h0001_2345, 32'h1234_5000, 1'b0);
    vec("slt", 4'b1000, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0);
    vec("slt_no", 4'b1000, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0);
    vec("mul_neg", 4'b1001, 32'hFFFF_FFFF, 32'h1, mul_on ? 32'hFFFF_FFFF : 32'h0, 1'b0);
    vec("mulh_neg", 4'b1011, 32'hFFFF_FFFF, 32'h1, mul_on ? 32'hFFFF_FFFF : 32'h0, 1'b0);
    vec("mul_min", 4'b1001, 32'h8000_0000, 32'h8000_0000, 32'h0, 1'b0);
    vec("mulh_min", 4'b1011, 32'h8000_0000, 32'h8000_0000, mul_on ? 32'h4000_0000 : 32'h0, 1'b0);
    vec("beq_t", 4'b1100, 32'd9, 32'd9, 32'hFFFF_FFFF, 1'b1);
    vec("bne_f", 4'b1101, 32'd9, 32'd9, 32'hFFFF_FFFF, 1'b0);
    vec("bgt_f", 4'b1110, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFF, 1'b0);
    vec("blt_t", 4'b1111, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFF, 1'b1);
    vec("blt_min", 4'b1111, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    vec("bgt_max", 4'b1110, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

    // Reset in the middle of operation, again without a clock edge.
    vec("pre_reset", 4'b0000, 32'd1, 32'd2, 32'd3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_result", result, 32'h0);
    @(posedge clk);
    #1;
    chk("reset_hold", result, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Random operands per op; inputs change every cycle.
    for (int op = 0; op < 16; op++) begin
      for (int i = 0; i < 1000; i++) begin
        @(posedge clk);
        #1;
        alu_op = 4'(op);
        a = pick();
        b = pick();
      end
    end

    // Back-to-back random ops.
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      alu_op = 4'($urandom_range(0, 15));
      a = pick();
      b = pick();
    end

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
